butterfly_32b_core: RTL and testbench
=====================================

BUTTERFLY_32B_CORE -- requirements
Module: butterfly_32b

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port list, in order:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input operands valid this cycle.
- din0_real, din0_imag  in  32  upper input A, signed two's complement integer.
- din1_real, din1_imag  in  32  lower input B, signed two's complement integer.
- w_real, w_imag  in  32  twiddle W, signed Q1.31 (value = w/2^31; 0x80000000 = -1.0).
- out_valid  out  1  outputs valid this cycle.
- dout0_real, dout0_imag  out  32  Y0, signed.
- dout1_real, dout1_imag  out  32  Y1, signed.
REQ-003 No parameters; all widths are fixed at 32.

Function
REQ-004 The block SHALL compute the radix-2 DIT butterfly with per-stage scaling:
- T = B*W
- Y0 = (A+T)/2
- Y1 = (A-T)/2
REQ-005 Complex product:
- Tr_full = Br*Wr - Bi*Wi; Ti_full = Br*Wi + Bi*Wr.
- Each is computed exactly in at least 65 bits signed.
- T = T_full arithmetic-shifted right 31, truncating toward minus infinity, kept in 34 bits signed.
REQ-006 Sums:
- A±T SHALL be formed in 35 bits signed.
- The result SHALL then be arithmetic-shifted right 1, truncating toward minus infinity.
REQ-007 Saturation: each output component SHALL clamp to the range 0x80000000..0x7FFFFFFF; no wrap-around.
REQ-008 Latency is 2 clock cycles.
- Stage 1 registers the four partial products, A, and the valid bit.
- Stage 2 registers the saturated outputs and out_valid.
REQ-009 out_valid SHALL equal in_valid delayed by exactly 2 cycles. Back-to-back inputs SHALL be accepted every cycle with no stall.
REQ-010 When in_valid is low, a pipeline stage SHALL hold its data registers; only the valid bit advances. The dout ports SHALL keep their last values while out_valid is low.
REQ-011 There SHALL be no backpressure or ready signal.

Reset
REQ-012 While rst is high at a clock edge, all pipeline registers SHALL be cleared:
- all dout* = 0x00000000
- out_valid = 0
REQ-013 If rst is asserted mid-operation, in-flight samples SHALL be discarded. out_valid SHALL stay 0 until 2 cycles after the first in_valid sampled with rst low.
REQ-014 If rst and in_valid are high in the same cycle, rst wins and the sample is dropped.

Configuration
REQ-015 Macro BUTTERFLY_32B_ROUND_EN controls rounding.
- Defined: both the >>31 product shift and the >>1 output shift SHALL round half up, by adding 2^30 and 1 respectively before shifting.
- Undefined: both shifts SHALL truncate as in REQ-005/REQ-006.
- Saturation and latency SHALL be identical in both builds.

Verification
REQ-016 Zero twiddle case.
- Stimulus: din0=(0xA14E2EBA,0), din1=(0xFBA4EE03,0), W=(0,0), in_valid=1.
- Response: 2 cycles later, out_valid=1; dout0=(0xD0A7175D,0); dout1=(0xD0A7175D,0). Result is the same in both ROUND_EN builds.
REQ-017 W = -1 case.
- Stimulus: din0=(0x10000000,0), din1=(0x04000000,0), W=(0x80000000,0).
- Response: dout0=(0x06000000,0); dout1=(0x0A000000,0).
REQ-018 W = -j case.
- Stimulus: din0=(0,0), din1=(0x02000000,0), W=(0,0x80000000).
- Response: dout0=(0,0xFF000000); dout1=(0,0x01000000).
REQ-019 Saturation case.
- Stimulus: din0=(0x7FFFFFFF,0), din1=(0x80000000,0x7FFFFFFF), W=(0x80000000,0x80000000).
- Response: dout0_real=0x7FFFFFFF (saturated); dout1_real=0xC0000000.
REQ-020 Reset mid-pipeline.
- Stimulus: apply a valid sample, then assert rst on the next cycle.
- Response: out_valid never rises for that sample; all dout*=0.
REQ-021 Streaming.
- Stimulus: 10 consecutive valid samples, then in_valid=0.
- Response: out_valid high for exactly 10 cycles starting 2 cycles later; results in order; outputs hold after the last sample.

Source files
------------

// File: rtl/butterfly_32b_core.sv
// Radix-2 DIT butterfly, Y0 = (A + B*W)/2 and Y1 = (A - B*W)/2, 32-bit complex, 2-cycle pipeline.
// Define BUTTERFLY_32B_ROUND_EN to round half up on both shifts; the default build truncates.
module butterfly_32b_core (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic signed [31:0] din0_real,
    input  logic signed [31:0] din0_imag,
    input  logic signed [31:0] din1_real,
    input  logic signed [31:0] din1_imag,
    input  logic signed [31:0] w_real,
    input  logic signed [31:0] w_imag,
    output logic               out_valid,
    output logic signed [31:0] dout0_real,
    output logic signed [31:0] dout0_imag,
    output logic signed [31:0] dout1_real,
    output logic signed [31:0] dout1_imag
);

`ifdef BUTTERFLY_32B_ROUND_EN
    localparam logic signed [64:0] PROD_BIAS = 65'sd1073741824;
    localparam logic signed [34:0] SUM_BIAS  = 35'sd1;
`else
    localparam logic signed [64:0] PROD_BIAS = 65'sd0;
    localparam logic signed [34:0] SUM_BIAS  = 35'sd0;
`endif

    // Stage 1 state: the four partial products of B*W, operand A and its valid bit.
    logic signed [63:0] ppBrWr_q, ppBiWi_q, ppBrWi_q, ppBiWr_q;
    logic signed [63:0] ppBrWr_d, ppBiWi_d, ppBrWi_d, ppBiWr_d;
    logic signed [31:0] aReal_q, aImag_q;
    logic               valid1_q;

    logic signed [31:0] y0Real_q, y0Imag_q, y1Real_q, y1Imag_q;
    logic signed [31:0] y0Real_d, y0Imag_d, y1Real_d, y1Imag_d;
    logic               valid2_q;

    logic signed [64:0] trFull, tiFull, trBiased, tiBiased;
    logic signed [33:0] tReal, tImag;

    // Halve a 35-bit sum (with optional half-up bias) and clamp it into 32 bits.
    function automatic logic signed [31:0] scaleSat(input logic signed [34:0] sum);
        logic signed [34:0] biased;
        logic signed [33:0] halved;
        logic signed [31:0] result;
        biased = sum + SUM_BIAS;
        halved = biased[34:1];
        if (halved[33:31] == 3'b000 || halved[33:31] == 3'b111) begin
            result = halved[31:0];
        end else if (halved[33]) begin
            result = 32'sh8000_0000;
        end else begin
            result = 32'sh7FFF_FFFF;
        end
        return result;
    endfunction

    assign ppBrWr_d = 64'(din1_real) * 64'(w_real);
    assign ppBiWi_d = 64'(din1_imag) * 64'(w_imag);
    assign ppBrWi_d = 64'(din1_real) * 64'(w_imag);
    assign ppBiWr_d = 64'(din1_imag) * 64'(w_real);

    always_ff @(posedge clk) begin
        if (rst) begin
            ppBrWr_q <= '0;
            ppBiWi_q <= '0;
            ppBrWi_q <= '0;
            ppBiWr_q <= '0;
            aReal_q  <= '0;
            aImag_q  <= '0;
            valid1_q <= 1'b0;
        end else begin
            valid1_q <= in_valid;
            if (in_valid) begin
                ppBrWr_q <= ppBrWr_d;
                ppBiWi_q <= ppBiWi_d;
                ppBrWi_q <= ppBrWi_d;
                ppBiWr_q <= ppBiWr_d;
                aReal_q  <= din0_real;
                aImag_q  <= din0_imag;
            end
        end
    end

    // 65 bits hold any sum or difference of two 64-bit products; >>31 of that fits in 34 bits.
    always_comb begin
        trFull   = 65'(ppBrWr_q) - 65'(ppBiWi_q);
        tiFull   = 65'(ppBrWi_q) + 65'(ppBiWr_q);
        trBiased = trFull + PROD_BIAS;
        tiBiased = tiFull + PROD_BIAS;
        tReal    = trBiased[64:31];
        tImag    = tiBiased[64:31];
        y0Real_d = scaleSat(35'(aReal_q) + 35'(tReal));
        y0Imag_d = scaleSat(35'(aImag_q) + 35'(tImag));
        y1Real_d = scaleSat(35'(aReal_q) - 35'(tReal));
        y1Imag_d = scaleSat(35'(aImag_q) - 35'(tImag));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y0Real_q <= '0;
            y0Imag_q <= '0;
            y1Real_q <= '0;
            y1Imag_q <= '0;
            valid2_q <= 1'b0;
        end else begin
            valid2_q <= valid1_q;
            if (valid1_q) begin
                y0Real_q <= y0Real_d;
                y0Imag_q <= y0Imag_d;
                y1Real_q <= y1Real_d;
                y1Imag_q <= y1Imag_d;
            end
        end
    end

    assign out_valid  = valid2_q;
    assign dout0_real = y0Real_q;
    assign dout0_imag = y0Imag_q;
    assign dout1_real = y1Real_q;
    assign dout1_imag = y1Imag_q;

endmodule

// File: tb/tb_butterfly_32b_core.sv
// Scoreboard bench for butterfly_32b_core: directed vectors with hand-computed results.
// Vectors whose result depends on BUTTERFLY_32B_ROUND_EN carry both expectations.
module tb_butterfly_32b_core;

`ifdef BUTTERFLY_32B_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] din0Real, din0Imag, din1Real, din1Imag, wReal, wImag;
    logic        outValid;
    logic [31:0] dout0Real, dout0Imag, dout1Real, dout1Imag;

    typedef struct {
        string       name;
        logic [31:0] y0r, y0i, y1r, y1i;
        int          due;
    } expT;

    expT         sb[$];
    int          checks;
    int          errors;
    int          cycleCount;
    logic [31:0] lastY0r, lastY0i, lastY1r, lastY1i;

    butterfly_32b_core dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .din0_real  (din0Real),
        .din0_imag  (din0Imag),
        .din1_real  (din1Real),
        .din1_imag  (din1Imag),
        .w_real     (wReal),
        .w_imag     (wImag),
        .out_valid  (outValid),
        .dout0_real (dout0Real),
        .dout0_imag (dout0Imag),
        .dout1_real (dout1Real),
        .dout1_imag (dout1Imag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Issue one valid sample and queue its expected result for two cycles later.
    task automatic applyStimulus(input string name,
                                 input logic [31:0] ar, input logic [31:0] ai,
                                 input logic [31:0] br, input logic [31:0] bi,
                                 input logic [31:0] wr, input logic [31:0] wi,
                                 input logic [31:0] e0r, input logic [31:0] e0i,
                                 input logic [31:0] e1r, input logic [31:0] e1i);
        expT e;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        din0Real = ar; din0Imag = ai;
        din1Real = br; din1Imag = bi;
        wReal    = wr; wImag    = wi;
        e.name = name;
        e.y0r = e0r; e.y0i = e0i; e.y1r = e1r; e.y1i = e1i;
        e.due = cycleCount + 2;
        sb.push_back(e);
        lastY0r = e0r; lastY0i = e0i; lastY1r = e1r; lastY1i = e1i;
    endtask

    // Invalid cycles carry random data that must not reach the outputs.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            din0Real = $urandom; din0Imag = $urandom;
            din1Real = $urandom; din1Imag = $urandom;
            wReal    = $urandom; wImag    = $urandom;
        end
    endtask

    task automatic checkIdle(input string name, input int n);
        repeat (n) begin
            @(negedge clk);
            checkOutput({name, " out_valid"}, {31'b0, outValid}, 32'd0);
            checkOutput({name, " dout0_real"}, dout0Real, lastY0r);
            checkOutput({name, " dout0_imag"}, dout0Imag, lastY0i);
            checkOutput({name, " dout1_real"}, dout1Real, lastY1r);
            checkOutput({name, " dout1_imag"}, dout1Imag, lastY1i);
        end
    endtask

    // Monitor: pops the scoreboard when a result is due and flags out_valid with nothing due.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due <= cycleCount) begin
            expT e;
            e = sb.pop_front();
            checkOutput({e.name, " out_valid"}, {31'b0, outValid}, 32'd1);
            if (outValid) begin
                checkOutput({e.name, " dout0_real"}, dout0Real, e.y0r);
                checkOutput({e.name, " dout0_imag"}, dout0Imag, e.y0i);
                checkOutput({e.name, " dout1_real"}, dout1Real, e.y1r);
                checkOutput({e.name, " dout1_imag"}, dout1Imag, e.y1i);
            end
        end else if (outValid) begin
            checkOutput("unexpected out_valid", {31'b0, outValid}, 32'd0);
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        cycleCount = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        din0Real = '0; din0Imag = '0; din1Real = '0; din1Imag = '0; wReal = '0; wImag = '0;
        lastY0r = '0; lastY0i = '0; lastY1r = '0; lastY1i = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkIdle("reset", 1);

        applyStimulus("zero_w", 32'hA14E2EBA, 0, 32'hFBA4EE03, 0, 0, 0,
                      32'hD0A7175D, 0, 32'hD0A7175D, 0);
        applyStimulus("w_minus1", 32'h10000000, 0, 32'h04000000, 0, 32'h80000000, 0,
                      32'h06000000, 0, 32'h0A000000, 0);
        applyStimulus("w_minus_j", 0, 0, 32'h02000000, 0, 0, 32'h80000000,
                      0, 32'hFF000000, 0, 32'h01000000);
        applyStimulus("sat_pos", 32'h7FFFFFFF, 0, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h80000000,
                      32'h7FFFFFFF, ROUND ? 32'd1 : 32'd0, 32'hC0000000, ROUND ? 32'd0 : 32'hFFFFFFFF);
        applyStimulus("sat_neg", 32'h80000000, 0, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h80000000,
                      ROUND ? 32'h40000000 : 32'h3FFFFFFF, ROUND ? 32'd1 : 32'd0,
                      32'h80000000, ROUND ? 32'd0 : 32'hFFFFFFFF);
        applyStimulus("odd_sum", 3, -3, 0, 0, 0, 0,
                      ROUND ? 32'd2 : 32'd1, ROUND ? -1 : -2, ROUND ? 32'd2 : 32'd1, ROUND ? -1 : -2);
        applyStimulus("prod_half_pos", 0, 0, 1, 0, 32'h40000000, 0,
                      ROUND ? 32'd1 : 32'd0, 0, 0, 0);
        applyStimulus("prod_half_neg", 0, 0, -1, 0, 32'h40000000, 0,
                      ROUND ? 32'd0 : -1, 0, 0, 0);
        idle(3);
        checkIdle("hold_directed", 2);

        // Valid sample followed by reset: it must never appear.
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        din0Real = 32'h12345678; din1Real = 32'h01000000; wReal = 32'h40000000;
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        lastY0r = '0; lastY0i = '0; lastY1r = '0; lastY1i = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkIdle("reset_mid", 4);

        // Reset and valid together: reset wins.
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b1;
        din0Real = 32'h00000100;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        checkIdle("reset_with_valid", 3);

        applyStimulus("s0", 100, -50, 40, 20, 32'h40000000, 0, 60, -20, 40, -30);
        applyStimulus("s1", -1000, 2000, 600, -400, 32'h80000000, 0, -800, 1200, -200, 800);
        applyStimulus("s2", 10, 20, 30, 40, 0, 32'h80000000, 25, -5, -15, 25);
        applyStimulus("s3", 0, 0, 8, 4, 32'h40000000, 32'h40000000, 1, 3, -1, -3);
        applyStimulus("s4", 32'h40000000, 0, 0, 0, 0, 0, 32'h20000000, 0, 32'h20000000, 0);
        applyStimulus("s5", -2, -4, 2, 4, 32'h80000000, 0, -2, -4, 0, 0);
        applyStimulus("s6", 1000000, -1000000, 2000000, 0, 32'h40000000, 0, 1000000, -500000, 0, -500000);
        applyStimulus("s7", 6, 6, -2, -2, 0, 32'h80000000, 2, 4, 4, 2);
        applyStimulus("s8", -100, -100, 100, 100, 32'h40000000, 32'h40000000, -50, 0, -50, -100);
        applyStimulus("s9", 32'h7FFFFFFE, 0, 32'h80000000, 0, 32'h80000000, 0, 32'h7FFFFFFF, 0, -1, 0);
        idle(3);
        checkIdle("hold_stream", 3);

        idle(2);
        checkOutput("scoreboard drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
